imm_extend_stage: RTL and testbench



---
 rtl/imm_extend_stage.sv | 166 ++++++++++++++++
 tb/tb_imm_extend_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_stage.sv
// Pipelined MIPS32 immediate generator with valid/ready handshake and flush.
// Optional two-entry storage with registered in_ready: define IMM_SKID_BUFFER_EN.
module imm_extend_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_imm,
    output logic [2:0]  out_mode,
    output logic        out_illegal,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned IMM_W  = 32;
    localparam int unsigned MODE_W = 3;
    localparam int unsigned OP_W   = 6;

    localparam logic [MODE_W-1:0] MODE_NONE   = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_SEXT   = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_ZEXT   = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_LUI    = MODE_W'(3);
    localparam logic [MODE_W-1:0] MODE_BRANCH = MODE_W'(4);
    localparam logic [MODE_W-1:0] MODE_JUMP   = MODE_W'(5);

    typedef struct packed {
        logic [IMM_W-1:0]  imm;
        logic [MODE_W-1:0] mode;
        logic              illegal;
    } imm_entry_t;

    logic [OP_W-1:0] op;
    logic [15:0]     imm16;
    logic [25:0]     tgt;
    imm_entry_t      dec_c;

    assign op    = in_instr[31:26];
    assign imm16 = in_instr[15:0];
    assign tgt   = in_instr[25:0];

    // Opcode classification and immediate formation
    always_comb begin
        dec_c = '0;
        case (op)
            6'h00: begin
                dec_c.mode = MODE_NONE;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: begin
                dec_c.imm  = {{16{imm16[15]}}, imm16};
                dec_c.mode = MODE_SEXT;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_c.imm  = {16'h0, imm16};
                dec_c.mode = MODE_ZEXT;
            end
            6'h0F: begin
                dec_c.imm  = {imm16, 16'h0};
                dec_c.mode = MODE_LUI;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec_c.imm  = {{14{imm16[15]}}, imm16, 2'b00};
                dec_c.mode = MODE_BRANCH;
            end
            6'h02, 6'h03: begin
                dec_c.imm  = {4'h0, tgt, 2'b00};
                dec_c.mode = MODE_JUMP;
            end
            default: begin
                dec_c.illegal = 1'b1;
            end
        endcase
    end

    imm_entry_t out_q;
    imm_entry_t out_d;
    logic       out_valid_q;
    logic       out_valid_d;

    assign out_imm     = out_q.imm;
    assign out_mode    = out_q.mode;
    assign out_illegal = out_q.illegal;
    assign out_valid   = out_valid_q;

`ifdef IMM_SKID_BUFFER_EN
    imm_entry_t skid_q;
    imm_entry_t skid_d;
    logic       skid_valid_q;
    logic       skid_valid_d;
    logic       in_ready_q;

    assign in_ready = in_ready_q;

    // A full skid implies in_ready is low, so no input is taken that cycle
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            if (!out_valid_q || out_ready) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec_c;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            out_d       = dec_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: decode table, backpressure, flush, async reset.
module tb_imm_extend_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_mode;
    logic        out_illegal;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    imm_extend_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_instr   (in_instr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_imm    (out_imm),
        .out_mode   (out_mode),
        .out_illegal(out_illegal),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  mode;
        logic        ill;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input int idx);
        chk({name, " imm"},  out_imm,              vecs[idx].imm);
        chk({name, " mode"}, 32'(out_mode),        32'(vecs[idx].mode));
        chk({name, " ill"},  32'(out_illegal),     32'(vecs[idx].ill));
    endtask

    function automatic int find_vec(input logic [31:0] ins);
        for (int k = 0; k < NV; k++)
            if (vecs[k].instr == ins) return k;
        return 0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] expq [$];
        int          seq [6];
        int          idx;
        int          delivered;
        int          held_acc;
        logic        acc;
        logic        drn;
        int          head;

        vecs[0]  = '{32'h2008FFFF, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'h3508FFFF, 32'h0000FFFF, 3'd2, 1'b0};
        vecs[2]  = '{32'h3C081234, 32'h12340000, 3'd3, 1'b0};
        vecs[3]  = '{32'h1000FFFE, 32'hFFFFFFF8, 3'd4, 1'b0};
        vecs[4]  = '{32'h08000040, 32'h00000100, 3'd5, 1'b0};
        vecs[5]  = '{32'hFC000000, 32'h00000000, 3'd0, 1'b1};
        vecs[6]  = '{32'h012A4020, 32'h00000000, 3'd0, 1'b0};
        vecs[7]  = '{32'h8C010004, 32'h00000004, 3'd1, 1'b0};
        vecs[8]  = '{32'h30E18000, 32'h00008000, 3'd2, 1'b0};
        vecs[9]  = '{32'h24018000, 32'hFFFF8000, 3'd1, 1'b0};
        vecs[10] = '{32'h0FFFFFFF, 32'h0FFFFFFC, 3'd5, 1'b0};
        vecs[11] = '{32'h1C20FFFF, 32'hFFFFFFFC, 3'd4, 1'b0};
        vecs[12] = '{32'h04010001, 32'h00000000, 3'd0, 1'b1};
        vecs[13] = '{32'hAC000010, 32'h00000010, 3'd1, 1'b0};
        vecs[14] = '{32'hA8000000, 32'h00000000, 3'd0, 1'b1};
        vecs[15] = '{32'h94007FFF, 32'h00007FFF, 3'd1, 1'b0};
        vecs[16] = '{32'hA0008001, 32'hFFFF8001, 3'd1, 1'b0};
        vecs[17] = '{32'h3800ABCD, 32'h0000ABCD, 3'd2, 1'b0};
        vecs[18] = '{32'h2C00FFFF, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[19] = '{32'h98001234, 32'h00000000, 3'd0, 1'b1};
        vecs[20] = '{32'hB0000000, 32'h00000000, 3'd0, 1'b1};
        vecs[21] = '{32'hA4000002, 32'h00000002, 3'd1, 1'b0};
        vecs[22] = '{32'h1D000001, 32'h00000004, 3'd4, 1'b0};
        vecs[23] = '{32'h0C000001, 32'h00000004, 3'd5, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_instr = '0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_imm",   out_imm,        32'd0);
        chk("reset out_mode",  32'(out_mode),  32'd0);
        chk("reset out_ill",   32'(out_illegal), 32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back decode stream with the consumer always ready
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = vecs[i].instr; out_ready = 1'b1;
            #1;
            chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
            chk_vec($sformatf("stream%0d", i), i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure: consumer stalls for three cycles while input keeps streaming
        seq = '{1, 2, 3, 4, 7, 8};
        idx = 0; delivered = 0; held_acc = 0;
        for (int cyc = 0; cyc < 40 && delivered < 6; cyc++) begin
            @(negedge clk);
            in_valid  = (idx < 6);
            in_instr  = (idx < 6) ? vecs[seq[idx]].instr : 32'h0;
            out_ready = (cyc >= 3);
            #4;
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (cyc == 1 || cyc == 2) begin
                chk($sformatf("stall%0d out_valid", cyc), 32'(out_valid), 32'd1);
                chk($sformatf("stall%0d out_imm", cyc), out_imm, vecs[seq[0]].imm);
            end
            if (cyc == 2) begin
                chk("stall in_ready", 32'(in_ready), 32'd0);
            end
            if (drn) begin
                if (expq.size() == 0) begin
                    chk("bp spurious output", 32'd1, 32'd0);
                end else begin
                    head = find_vec(expq.pop_front());
                    chk_vec($sformatf("bp out%0d", delivered), head);
                    delivered++;
                end
            end
            if (acc) begin
                expq.push_back(in_instr);
                idx++;
                if (cyc < 3) held_acc++;
            end
            @(posedge clk);
        end
`ifdef IMM_SKID_BUFFER_EN
        chk("bp accepted while stalled", 32'(held_acc), 32'd2);
`else
        chk("bp accepted while stalled", 32'(held_acc), 32'd1);
`endif
        chk("bp delivered", 32'(delivered), 32'd6);
        chk("bp leftover", 32'(expq.size()), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp empty after", 32'(out_valid), 32'd0);

        // Flush with storage full; the same-cycle input must be dropped too
        @(negedge clk);
        in_valid = 1'b1; in_instr = vecs[9].instr; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_instr = vecs[10].instr;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_instr = vecs[11].instr; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-flush%0d out_valid", c), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b1; in_instr = vecs[13].instr;
        @(posedge clk);
        #1;
        chk("post-flush out_valid", 32'(out_valid), 32'd1);
        chk_vec("post-flush", 13);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);

        // Asynchronous reset between edges while holding data
        @(negedge clk);
        in_valid = 1'b1; in_instr = vecs[16].instr; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_instr = vecs[17].instr;
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_imm",   out_imm,        32'd0);
        chk("async rst out_mode",  32'(out_mode),  32'd0);
        chk("async rst out_ill",   32'(out_illegal), 32'd0);
        chk("async rst in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after rst idle", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b1; in_instr = vecs[5].instr;
        @(posedge clk);
        #1;
        chk("after rst out_valid", 32'(out_valid), 32'd1);
        chk_vec("after rst", 5);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
